paddle_position_ctrl: RTL and testbench

Downstream consumer of the PS/2 mouse decoder. Takes each decoded mouse update (direction, speed, error, new-data flag), accumulates vertical motion between video frames, and applies it to the paddle's top-edge Y coordinate once per frame, clamped to the playfield. Its output drives the paddle renderer and the collision logic.

---
 rtl/paddle_position_ctrl_if.sv | 24 ++
 rtl/paddle_position_ctrl.sv | 117 +++++++++++
 tb/tb_paddle_position_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/paddle_position_ctrl_if.sv
// Mouse-update, frame-timing and paddle-state signals shared between the
// paddle position controller and its driver.
interface paddle_position_ctrl_if;
    logic       enable;
    logic       paddle_dir;
    logic [7:0] paddle_speed;
    logic       error_flag;
    logic       new_output_flag;
    logic       frame_tick;
    logic [9:0] paddle_y;
    logic       moving;
    logic       update_done;
    logic [7:0] error_count;

    modport master (
        output enable, paddle_dir, paddle_speed, error_flag, new_output_flag, frame_tick,
        input  paddle_y, moving, update_done, error_count
    );

    modport slave (
        input  enable, paddle_dir, paddle_speed, error_flag, new_output_flag, frame_tick,
        output paddle_y, moving, update_done, error_count
    );
endinterface

// File: rtl/paddle_position_ctrl.sv
// Accumulates decoded mouse motion between frames and applies it to the
// paddle top-edge Y coordinate once per frame, clamped to the playfield.
module paddle_position_ctrl #(
    parameter int SCREEN_HEIGHT = 480,
    parameter int PADDLE_HEIGHT = 64,
    parameter int Y_INIT        = 208,
    parameter int SPEED_SHIFT   = 1,
    parameter int MAX_STEP      = 16,
    parameter int ACC_LIMIT     = 255
) (
    input  logic                    clk_25MHz,
    input  logic                    reset,
    paddle_position_ctrl_if.slave   bus
);
    localparam logic signed [11:0] ACC_MAX    = 12'(ACC_LIMIT);
    localparam logic signed [11:0] ACC_MIN    = -12'(ACC_LIMIT);
    localparam logic signed [12:0] Y_MAX      = 13'(SCREEN_HEIGHT - PADDLE_HEIGHT);
    localparam logic [7:0]         MAX_STEP_8 = 8'(MAX_STEP);
    localparam logic [9:0]         Y_INIT_10  = 10'(Y_INIT);

    typedef enum logic {ACCUM, APPLY} state_t;

    state_t             state_q, state_d;
    logic               flag_q, flag_d;
    logic signed [11:0] acc_q, acc_d;
    logic [9:0]         paddle_y_q, paddle_y_d;
    logic               moving_q, moving_d;
    logic [7:0]         error_count_q, error_count_d;

    logic               pkt_evt;
    logic [7:0]         shifted;
    logic [7:0]         step;
    logic signed [11:0] delta;
    logic signed [11:0] sum;
    logic signed [11:0] acc_sat;
    logic signed [12:0] y_sum;

    always_comb begin
        state_d       = ACCUM;
        flag_d        = bus.new_output_flag;
        acc_d         = acc_q;
        paddle_y_d    = paddle_y_q;
        moving_d      = moving_q;
        error_count_d = error_count_q;
        delta         = '0;
        y_sum         = '0;

        pkt_evt = bus.new_output_flag && !flag_q;
        shifted = bus.paddle_speed >> SPEED_SHIFT;
        step    = (shifted > MAX_STEP_8) ? MAX_STEP_8 : shifted;

        if (pkt_evt && bus.enable && !bus.error_flag) begin
            delta = bus.paddle_dir ? -$signed({4'b0000, step}) : $signed({4'b0000, step});
        end

        sum = acc_q + delta;
        if (sum > ACC_MAX) begin
            acc_sat = ACC_MAX;
        end else if (sum < ACC_MIN) begin
            acc_sat = ACC_MIN;
        end else begin
            acc_sat = sum;
        end

        if (pkt_evt && bus.enable && bus.error_flag && (error_count_q != '1)) begin
            error_count_d = error_count_q + 8'd1;
        end

        // While disabled acc is pinned at 0 so nothing leaks into the next frame.
        if (!bus.enable) begin
            acc_d = '0;
            if (bus.frame_tick) begin
                moving_d = 1'b0;
            end
        end else if (bus.frame_tick) begin
            y_sum = $signed({3'b000, paddle_y_q}) + $signed({acc_sat[11], acc_sat});
            if (y_sum < 0) begin
                paddle_y_d = '0;
            end else if (y_sum > Y_MAX) begin
                paddle_y_d = Y_MAX[9:0];
            end else begin
                paddle_y_d = y_sum[9:0];
            end
            moving_d = (acc_sat != 0);
            acc_d    = '0;
        end else begin
            acc_d = acc_sat;
        end

        if (bus.frame_tick) begin
            state_d = APPLY;
        end
    end

    always_ff @(posedge clk_25MHz or negedge reset) begin
        if (!reset) begin
            state_q       <= ACCUM;
            flag_q        <= 1'b0;
            acc_q         <= '0;
            paddle_y_q    <= Y_INIT_10;
            moving_q      <= 1'b0;
            error_count_q <= '0;
        end else begin
            state_q       <= state_d;
            flag_q        <= flag_d;
            acc_q         <= acc_d;
            paddle_y_q    <= paddle_y_d;
            moving_q      <= moving_d;
            error_count_q <= error_count_d;
        end
    end

    assign bus.paddle_y    = paddle_y_q;
    assign bus.moving      = moving_q;
    assign bus.update_done = (state_q == APPLY);
    assign bus.error_count = error_count_q;
endmodule

// File: tb/tb_paddle_position_ctrl.sv
// Directed bench for paddle_position_ctrl: hand-computed paddle positions,
// flags and error counts checked scenario by scenario.
module tb_paddle_position_ctrl;
    logic clk_25MHz;
    logic reset;
    int   total;
    int   bad;

    paddle_position_ctrl_if bus ();

    paddle_position_ctrl dut (
        .clk_25MHz (clk_25MHz),
        .reset     (reset),
        .bus       (bus)
    );

    initial begin
        clk_25MHz = 1'b0;
        forever #20 clk_25MHz = ~clk_25MHz;
    end

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_25MHz);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.enable = 1'b1;
        bus.paddle_dir = 1'b0;
        bus.paddle_speed = '0;
        bus.error_flag = 1'b0;
        bus.new_output_flag = 1'b0;
        bus.frame_tick = 1'b0;
        cyc(2);
        reset = 1'b1;
        cyc(1);
    endtask

    task automatic send_pkt(input logic dir, input logic [7:0] speed, input logic err);
        bus.paddle_dir = dir;
        bus.paddle_speed = speed;
        bus.error_flag = err;
        bus.new_output_flag = 1'b1;
        cyc(1);
        bus.new_output_flag = 1'b0;
        bus.error_flag = 1'b0;
        cyc(1);
    endtask

    task automatic do_tick();
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.paddle_y !== 10'd208) begin bad++; $display("FAIL reset_y got=%0d exp=208", bus.paddle_y); end
        total++; if (bus.error_count !== 8'd0) begin bad++; $display("FAIL reset_err got=%0d exp=0", bus.error_count); end
        total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL reset_moving got=%0b exp=0", bus.moving); end
        total++; if (bus.update_done !== 1'b0) begin bad++; $display("FAIL reset_ud got=%0b exp=0", bus.update_done); end
        // Build state, then assert reset between clock edges.
        send_pkt(1'b0, 8'd20, 1'b0);
        do_tick();
        send_pkt(1'b0, 8'd1, 1'b1);
        send_pkt(1'b0, 8'd30, 1'b0);
        #5 reset = 1'b0;
        #1;
        total++; if (bus.paddle_y !== 10'd208) begin bad++; $display("FAIL async_reset_y got=%0d exp=208", bus.paddle_y); end
        total++; if (bus.error_count !== 8'd0) begin bad++; $display("FAIL async_reset_err got=%0d exp=0", bus.error_count); end
        total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL async_reset_moving got=%0b exp=0", bus.moving); end
        total++; if (bus.update_done !== 1'b0) begin bad++; $display("FAIL async_reset_ud got=%0b exp=0", bus.update_done); end
        cyc(1);
        reset = 1'b1;
        cyc(3);
        total++; if (bus.paddle_y !== 10'd208) begin bad++; $display("FAIL post_reset_idle_y got=%0d exp=208", bus.paddle_y); end
        do_tick();
        total++; if (bus.paddle_y !== 10'd208) begin bad++; $display("FAIL post_reset_tick_y got=%0d exp=208", bus.paddle_y); end
        total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL post_reset_tick_moving got=%0b exp=0", bus.moving); end
    endtask

    task automatic test_single_move();
        do_reset();
        send_pkt(1'b0, 8'd20, 1'b0);
        do_tick();
        total++; if (bus.paddle_y !== 10'd218) begin bad++; $display("FAIL single_y got=%0d exp=218", bus.paddle_y); end
        total++; if (bus.moving !== 1'b1) begin bad++; $display("FAIL single_moving got=%0b exp=1", bus.moving); end
        total++; if (bus.update_done !== 1'b1) begin bad++; $display("FAIL single_ud got=%0b exp=1", bus.update_done); end
        cyc(1);
        total++; if (bus.update_done !== 1'b0) begin bad++; $display("FAIL single_ud_pulse got=%0b exp=0", bus.update_done); end
        do_tick();
        total++; if (bus.paddle_y !== 10'd218) begin bad++; $display("FAIL second_tick_y got=%0d exp=218", bus.paddle_y); end
        total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL second_tick_moving got=%0b exp=0", bus.moving); end
    endtask

    task automatic test_step_clamp();
        do_reset();
        for (int i = 0; i < 3; i++) send_pkt(1'b1, 8'd200, 1'b0);
        do_tick();
        total++; if (bus.paddle_y !== 10'd160) begin bad++; $display("FAIL step_clamp_y got=%0d exp=160", bus.paddle_y); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) send_pkt(1'b0, 8'd255, 1'b0);
        do_tick();
        total++; if (bus.paddle_y !== 10'd416) begin bad++; $display("FAIL bottom_clamp_y got=%0d exp=416", bus.paddle_y); end
        send_pkt(1'b0, 8'd40, 1'b0);
        do_tick();
        total++; if (bus.paddle_y !== 10'd416) begin bad++; $display("FAIL bottom_hold_y got=%0d exp=416", bus.paddle_y); end
        total++; if (bus.moving !== 1'b1) begin bad++; $display("FAIL bottom_hold_moving got=%0b exp=1", bus.moving); end
        // Negative saturation: 416 - 255 = 161 (unsaturated would be 96).
        for (int i = 0; i < 20; i++) send_pkt(1'b1, 8'd255, 1'b0);
        do_tick();
        total++; if (bus.paddle_y !== 10'd161) begin bad++; $display("FAIL neg_sat_y got=%0d exp=161", bus.paddle_y); end
        do_reset();
        for (int i = 0; i < 12; i++) send_pkt(1'b1, 8'd32, 1'b0);
        send_pkt(1'b1, 8'd12, 1'b0);
        do_tick();
        total++; if (bus.paddle_y !== 10'd10) begin bad++; $display("FAIL reach_10_y got=%0d exp=10", bus.paddle_y); end
        for (int i = 0; i < 3; i++) send_pkt(1'b1, 8'd200, 1'b0);
        do_tick();
        total++; if (bus.paddle_y !== 10'd0) begin bad++; $display("FAIL top_clamp_y got=%0d exp=0", bus.paddle_y); end
        // Saturated +255 then -16 gives 239; no saturation would give 304.
        for (int i = 0; i < 20; i++) send_pkt(1'b0, 8'd255, 1'b0);
        send_pkt(1'b1, 8'd32, 1'b0);
        do_tick();
        total++; if (bus.paddle_y !== 10'd239) begin bad++; $display("FAIL pos_sat_y got=%0d exp=239", bus.paddle_y); end
    endtask

    task automatic test_error_level();
        do_reset();
        bus.error_flag = 1'b1;
        bus.paddle_speed = 8'd40;
        bus.new_output_flag = 1'b1;
        cyc(5);
        bus.new_output_flag = 1'b0;
        bus.error_flag = 1'b0;
        cyc(1);
        total++; if (bus.error_count !== 8'd1) begin bad++; $display("FAIL err_level_count got=%0d exp=1", bus.error_count); end
        do_tick();
        total++; if (bus.paddle_y !== 10'd208) begin bad++; $display("FAIL err_no_move_y got=%0d exp=208", bus.paddle_y); end
        total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL err_no_move_moving got=%0b exp=0", bus.moving); end
        bus.paddle_dir = 1'b0;
        bus.paddle_speed = 8'd20;
        bus.new_output_flag = 1'b1;
        cyc(5);
        bus.new_output_flag = 1'b0;
        cyc(1);
        do_tick();
        total++; if (bus.paddle_y !== 10'd218) begin bad++; $display("FAIL level_once_y got=%0d exp=218", bus.paddle_y); end
        for (int i = 0; i < 253; i++) send_pkt(1'b0, 8'd4, 1'b1);
        total++; if (bus.error_count !== 8'd254) begin bad++; $display("FAIL err_254 got=%0d exp=254", bus.error_count); end
        for (int i = 0; i < 47; i++) send_pkt(1'b0, 8'd4, 1'b1);
        total++; if (bus.error_count !== 8'd255) begin bad++; $display("FAIL err_sat got=%0d exp=255", bus.error_count); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        send_pkt(1'b0, 8'd12, 1'b0);
        bus.paddle_dir = 1'b0;
        bus.paddle_speed = 8'd8;
        bus.new_output_flag = 1'b1;
        bus.frame_tick = 1'b1;
        cyc(1);
        bus.new_output_flag = 1'b0;
        bus.frame_tick = 1'b0;
        total++; if (bus.paddle_y !== 10'd218) begin bad++; $display("FAIL simul_y got=%0d exp=218", bus.paddle_y); end
        do_tick();
        total++; if (bus.paddle_y !== 10'd218) begin bad++; $display("FAIL simul_acc_clear_y got=%0d exp=218", bus.paddle_y); end
        total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL simul_acc_clear_moving got=%0b exp=0", bus.moving); end
    endtask

    task automatic test_enable();
        do_reset();
        send_pkt(1'b0, 8'd20, 1'b0);
        do_tick();
        bus.enable = 1'b0;
        send_pkt(1'b0, 8'd40, 1'b0);
        send_pkt(1'b1, 8'd40, 1'b1);
        do_tick();
        total++; if (bus.paddle_y !== 10'd218) begin bad++; $display("FAIL dis_y got=%0d exp=218", bus.paddle_y); end
        total++; if (bus.update_done !== 1'b1) begin bad++; $display("FAIL dis_ud got=%0b exp=1", bus.update_done); end
        total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL dis_moving got=%0b exp=0", bus.moving); end
        total++; if (bus.error_count !== 8'd0) begin bad++; $display("FAIL dis_err got=%0d exp=0", bus.error_count); end
        send_pkt(1'b0, 8'd40, 1'b0);
        bus.enable = 1'b1;
        cyc(1);
        do_tick();
        total++; if (bus.paddle_y !== 10'd218) begin bad++; $display("FAIL reen_y got=%0d exp=218", bus.paddle_y); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_pkt(1'b0, 8'd20, 1'b0);
        bus.frame_tick = 1'b1;
        cyc(1);
        total++; if (bus.paddle_y !== 10'd218) begin bad++; $display("FAIL b2b_first_y got=%0d exp=218", bus.paddle_y); end
        total++; if (bus.moving !== 1'b1) begin bad++; $display("FAIL b2b_first_moving got=%0b exp=1", bus.moving); end
        cyc(1);
        bus.frame_tick = 1'b0;
        total++; if (bus.update_done !== 1'b1) begin bad++; $display("FAIL b2b_second_ud got=%0b exp=1", bus.update_done); end
        total++; if (bus.moving !== 1'b0) begin bad++; $display("FAIL b2b_second_moving got=%0b exp=0", bus.moving); end
        cyc(1);
        total++; if (bus.update_done !== 1'b0) begin bad++; $display("FAIL b2b_ud_drop got=%0b exp=0", bus.update_done); end
        // Packet landing during APPLY counts toward the next frame.
        do_tick();
        send_pkt(1'b1, 8'd16, 1'b0);
        do_tick();
        total++; if (bus.paddle_y !== 10'd210) begin bad++; $display("FAIL apply_pkt_y got=%0d exp=210", bus.paddle_y); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single_move();
        test_step_clamp();
        test_saturation();
        test_error_level();
        test_simultaneous();
        test_enable();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
